// File: rtl/potential_adder.sv
// ============================================================================
//  Module   : potential_adder (with helper fp32_addsub)
//  Purpose  : per-neuron FP32 membrane-potential accumulator, one timestep at a time
//  Option   : POTENTIAL_SATURATE_EN clamps inf/NaN sums to the largest finite value
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp32_addsub (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] y_o,
  output logic        exc_o
);
  logic        sa, sb, sl, ss, swap;
  logic        nan_a, nan_b, inf_a, inf_b, rnd;
  logic [7:0]  ea, eb, el, es, d;
  logic [23:0] ml, ms;
  logic [26:0] xl, xs, xs_sh, xs_mask, nrm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_n, e_r;
  logic [24:0] mr;

  always_comb begin
    sa    = a_i[31];
    sb    = b_i[31] ^ sub_i;
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    nan_a = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    inf_a = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b_i[22:0] == 23'd0);

    // Order operands by magnitude so the subtraction below never borrows.
    swap = b_i[30:0] > a_i[30:0];
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    ml   = swap ? {eb != 8'd0, b_i[22:0]} : {ea != 8'd0, a_i[22:0]};
    ms   = swap ? {ea != 8'd0, a_i[22:0]} : {eb != 8'd0, b_i[22:0]};
    if (el == 8'd0) el = 8'd1;
    if (es == 8'd0) es = 8'd1;
    d  = el - es;

    xl      = {ml, 3'b000};
    xs_sh   = 27'd0;
    xs_mask = 27'd0;
    if (d >= 8'd27) begin
      xs = {26'd0, |ms};
    end else begin
      xs_sh   = {ms, 3'b000} >> d;
      xs_mask = (27'd1 << d) - 27'd1;
      xs      = {xs_sh[26:1], xs_sh[0] | (|({ms, 3'b000} & xs_mask))};
    end

    sum = (sl == ss) ? ({1'b0, xl} + {1'b0, xs}) : ({1'b0, xl} - {1'b0, xs});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    // Normalise; results too small for a normal exponent become subnormal.
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e_n = {2'b00, el} + 10'd1;
    end else if ({3'b000, lz} < el) begin
      nrm = sum[26:0] << lz;
      e_n = {2'b00, el} - {5'd0, lz};
    end else begin
      nrm = sum[26:0] << (el - 8'd1);
      e_n = 10'd0;
    end

    rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr  = {1'b0, nrm[26:3]} + {24'd0, rnd};
    e_r = e_n + {9'd0, mr[24]};
    if ((e_r == 10'd0) && mr[23]) e_r = 10'd1;

    exc_o = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      y_o   = 32'h7FC00000;
      exc_o = 1'b1;
    end else if (inf_a) begin
      y_o = {sa, 8'hFF, 23'd0};
    end else if (inf_b) begin
      y_o = {sb, 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      y_o = {sl & ss, 31'd0};
    end else if (e_r >= 10'd255) begin
      y_o   = {sl, 8'hFF, 23'd0};
      exc_o = 1'b1;
    end else begin
      y_o = {sl, e_r[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
  end
endmodule

module potential_adder #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] neuron_address_initialization,
  input  logic [31:0]           decayed_potential,
  input  logic                  weight_valid,
  input  logic [31:0]           weight,
  output logic                  weight_ready,
  input  logic                  timestep_end,
  output logic [31:0]           new_potential,
  output logic                  new_potential_valid,
  output logic [ADDR_WIDTH-1:0] neuron_address,
  output logic [CNT_WIDTH-1:0]  spike_count,
  output logic                  exception_flag,
  output logic                  busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           np_q, np_d;
  logic                  npv_q, npv_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  exc_q, exc_d;
  logic                  load, hs;
  logic [31:0]           sum, sum_sat;
  logic                  sum_exc;

  fp32_addsub u_add (
    .a_i   (acc_q),
    .b_i   (weight),
    .sub_i (1'b0),
    .y_o   (sum),
    .exc_o (sum_exc)
  );

`ifdef POTENTIAL_SATURATE_EN
  always_comb begin
    sum_sat = sum;
    if (sum[30:23] == 8'hFF) begin
      sum_sat = (sum[22:0] != 23'd0) ? 32'h7F7FFFFF : {sum[31], 31'h7F7FFFFF};
    end
  end
`else
  assign sum_sat = sum;
`endif

  assign hs = weight_valid && (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    np_d    = np_q;
    npv_d   = 1'b0;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // A clear aborts the timestep and drops any weight offered alongside it.
        if (clear) begin
          load = 1'b1;
        end else begin
          if (hs) begin
            acc_d = sum_sat;
            if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
            if (sum_exc) exc_d = 1'b1;
          end
          if (timestep_end) state_d = FLUSH;
        end
      end
      FLUSH: begin
        np_d  = acc_q;
        npv_d = 1'b1;
        if (clear) begin
          load    = 1'b1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      acc_d  = decayed_potential;
      addr_d = neuron_address_initialization;
      cnt_d  = '0;
      exc_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      np_q    <= '0;
      npv_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      np_q    <= np_d;
      npv_q   <= npv_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  assign weight_ready        = (state_q == ACCUM);
  assign busy                = (state_q != IDLE);
  assign new_potential       = np_q;
  assign new_potential_valid = npv_q;
  assign neuron_address      = addr_q;
  assign spike_count         = cnt_q;
  assign exception_flag      = exc_q;
endmodule

`default_nettype wire

// File: tb/tb_potential_adder.sv
// ============================================================================
//  Module   : tb_potential_adder
//  Purpose  : directed self-checking bench for potential_adder
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_potential_adder;
  localparam int AW = 12;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [AW-1:0] neuron_address_initialization = '0;
  logic [31:0]   decayed_potential = '0;
  logic          weight_valid = 1'b0;
  logic [31:0]   weight = '0;
  logic          weight_ready;
  logic          timestep_end = 1'b0;
  logic [31:0]   new_potential;
  logic          new_potential_valid;
  logic [AW-1:0] neuron_address;
  logic [CW-1:0] spike_count;
  logic          exception_flag;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [31:0]   last_pot = '0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   ovf_exp;

  potential_adder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK                           (CLK),
    .reset                         (reset),
    .clear                         (clear),
    .neuron_address_initialization (neuron_address_initialization),
    .decayed_potential             (decayed_potential),
    .weight_valid                  (weight_valid),
    .weight                        (weight),
    .weight_ready                  (weight_ready),
    .timestep_end                  (timestep_end),
    .new_potential                 (new_potential),
    .new_potential_valid           (new_potential_valid),
    .neuron_address                (neuron_address),
    .spike_count                   (spike_count),
    .exception_flag                (exception_flag),
    .busy                          (busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (new_potential_valid) begin
      vcount    <= vcount + 1;
      last_pot  <= new_potential;
      last_addr <= neuron_address;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear(input logic [31:0] dp, input logic [AW-1:0] addr);
    decayed_potential             = dp;
    neuron_address_initialization = addr;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic send_weight(input logic [31:0] w);
    weight_valid = 1'b1;
    weight       = w;
    tick;
    weight_valid = 1'b0;
  endtask

  task automatic end_ts(input string tag, input bit with_w, input logic [31:0] w,
                        input logic [31:0] exp_pot, input logic [AW-1:0] exp_addr,
                        input logic [31:0] exp_cnt, input logic exp_exc);
    int v0;
    v0           = vcount;
    weight_valid = with_w;
    weight       = w;
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    weight_valid = 1'b0;
    repeat (4) tick;
    check({tag, " pulses"}, 32'(vcount - v0), 32'd1);
    check({tag, " pot"}, last_pot, exp_pot);
    check({tag, " pot_hold"}, new_potential, exp_pot);
    check({tag, " addr"}, 32'(last_addr), 32'(exp_addr));
    check({tag, " cnt"}, 32'(spike_count), exp_cnt);
    check({tag, " exc"}, 32'(exception_flag), 32'(exp_exc));
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int v0;
`ifdef POTENTIAL_SATURATE_EN
    ovf_exp = 32'h7F7FFFFF;
`else
    ovf_exp = 32'h7F800000;
`endif
    #1;
    check("rst pot", new_potential, 32'd0);
    check("rst valid", 32'(new_potential_valid), 32'd0);
    check("rst ready", 32'(weight_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cnt", 32'(spike_count), 32'd0);
    check("rst addr", 32'(neuron_address), 32'd0);
    tick;
    reset = 1'b0;
    tick;

    do_clear(32'h3F800000, 12'h005);
    check("basic ready", 32'(weight_ready), 32'd1);
    send_weight(32'h3F000000);
    send_weight(32'h3F800000);
    check("basic cnt2", 32'(spike_count), 32'd2);
    end_ts("basic", 1'b0, 32'd0, 32'h40200000, 12'h005, 32'd2, 1'b0);

    do_clear(32'h40000000, 12'h00A);
    send_weight(32'hBF800000);
    end_ts("inhib", 1'b0, 32'd0, 32'h3F800000, 12'h00A, 32'd1, 1'b0);

    do_clear(32'h3F800000, 12'h0F0);
    end_ts("simul", 1'b1, 32'h3F000000, 32'h3FC00000, 12'h0F0, 32'd1, 1'b0);

    weight_valid = 1'b1;
    weight       = 32'h3F800000;
    tick;
    tick;
    check("idle ready", 32'(weight_ready), 32'd0);
    check("idle cnt", 32'(spike_count), 32'd1);
    weight_valid = 1'b0;
    v0 = vcount;
    do_clear(32'h3F800000, 12'h011);
    send_weight(32'h40000000);
    check("abort cnt1", 32'(spike_count), 32'd1);
    decayed_potential             = 32'h00000000;
    neuron_address_initialization = 12'h022;
    clear        = 1'b1;
    weight_valid = 1'b1;
    weight       = 32'h3F800000;
    tick;
    clear        = 1'b0;
    weight_valid = 1'b0;
    check("abort cnt0", 32'(spike_count), 32'd0);
    check("abort ready", 32'(weight_ready), 32'd1);
    check("abort nopulse", 32'(vcount - v0), 32'd0);
    end_ts("abort", 1'b0, 32'd0, 32'h00000000, 12'h022, 32'd0, 1'b0);

    do_clear(32'h7F7FFFFF, 12'h0AA);
    send_weight(32'h7F7FFFFF);
    check("ovf flag", 32'(exception_flag), 32'd1);
    end_ts("ovf", 1'b0, 32'd0, ovf_exp, 12'h0AA, 32'd1, 1'b1);

    do_clear(32'h00000000, 12'h123);
    repeat (9) send_weight(32'h3F800000);
    check("sat cnt", 32'(spike_count), 32'd7);
    v0 = vcount;
    timestep_end = 1'b1;
    tick;
    timestep_end = 1'b0;
    decayed_potential             = 32'h00000000;
    neuron_address_initialization = 12'h033;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (3) tick;
    check("flushclr pulses", 32'(vcount - v0), 32'd1);
    check("flushclr pot", last_pot, 32'h41100000);
    check("flushclr busy", 32'(busy), 32'd1);
    check("flushclr cnt", 32'(spike_count), 32'd0);

    repeat (3) send_weight(32'h3F800000);
    check("pre-rst cnt", 32'(spike_count), 32'd3);
    v0 = vcount;
    #2;
    reset = 1'b1;
    #1;
    check("arst pot", new_potential, 32'd0);
    check("arst addr", 32'(neuron_address), 32'd0);
    check("arst cnt", 32'(spike_count), 32'd0);
    check("arst exc", 32'(exception_flag), 32'd0);
    check("arst ready", 32'(weight_ready), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst valid", 32'(new_potential_valid), 32'd0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    check("arst idle", 32'(busy), 32'd0);
    check("arst nopulse", 32'(vcount - v0), 32'd0);
    do_clear(32'h40400000, 12'hABC);
    send_weight(32'h3F800000);
    end_ts("post-rst", 1'b0, 32'd0, 32'h40800000, 12'hABC, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
